// File: rtl/bcd_pkg.sv
// bcd_pkg: shared digit type, limits, FSM encoding and preset clamp for the BCD down-counter
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  function automatic bcd_digit_t bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/bcd_digit_down.sv
// bcd_digit_down: one decade of a BCD down-counter with load and borrow-out
module bcd_digit_down
  import bcd_pkg::*;
#(
  parameter bcd_digit_t RST = BCD_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  bcd_digit_t din,
  output bcd_digit_t q,
  output logic       borrow
);
  bcd_digit_t r_q;
  // load wins over decrement; decrementing from 0 wraps to 9 and borrows
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_q <= RST;
    else if (load) r_q <= din;
    else if (en) r_q <= (r_q == 4'd0) ? BCD_MAX : r_q - 4'd1;
  assign q      = r_q;
  assign borrow = en && (r_q == 4'd0);
endmodule

// File: rtl/bcd_downcounter.sv
// bcd_downcounter: two-digit BCD countdown timer; BCD_DOWNCOUNTER_AUTO_RELOAD_EN makes expiry reload the preset
module bcd_downcounter
  import bcd_pkg::*;
#(
  parameter logic [3:0] START_TENS = 4'd9,
  parameter logic [3:0] START_ONES = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] din_tens,
  input  logic [3:0] din_ones,
  input  logic       start,
  input  logic       ce,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [7:0] cout,
  output logic       zero,
  output logic       busy,
  output logic       done
);
  logic [1:0] r_state;
  bcd_digit_t r_pre_tens, r_pre_ones;
  logic       r_done;
  logic       w_expire, w_reload, w_ld, w_dec, w_borrow, w_borrow_t, w_pre_zero;
  logic [1:0] w_exp_state;
  bcd_digit_t w_din_t, w_din_o;
  assign w_pre_zero = (r_pre_tens == 4'd0) && (r_pre_ones == 4'd0);
  assign w_expire   = !load && !start && (r_state == RUN) && ce && (tens == 4'd0) && (ones == 4'd1);
`ifdef BCD_DOWNCOUNTER_AUTO_RELOAD_EN
  assign w_reload    = w_expire;
  assign w_exp_state = RUN;
`else
  assign w_reload    = 1'b0;
  assign w_exp_state = DONE;
`endif
  assign w_ld    = load || start || w_reload;
  assign w_dec   = !load && !start && !w_reload && (r_state == RUN) && ce;
  assign w_din_t = load ? bcd_clamp(din_tens) : r_pre_tens;
  assign w_din_o = load ? bcd_clamp(din_ones) : r_pre_ones;
  bcd_digit_down #(.RST(START_TENS)) u_tens (
    .clk(clk), .rst_n(rst_n), .en(w_borrow), .load(w_ld), .din(w_din_t), .q(tens), .borrow(w_borrow_t)
  );
  bcd_digit_down #(.RST(START_ONES)) u_ones (
    .clk(clk), .rst_n(rst_n), .en(w_dec), .load(w_ld), .din(w_din_o), .q(ones), .borrow(w_borrow)
  );
  // preset register captures the clamped digits on load
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pre_tens <= START_TENS;
      r_pre_ones <= START_ONES;
    end else if (load) begin
      r_pre_tens <= bcd_clamp(din_tens);
      r_pre_ones <= bcd_clamp(din_ones);
    end
  // control FSM: load aborts to IDLE, start (re)launches from the preset, expiry ends or reloads
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else if (load) r_state <= IDLE;
    else if (start) r_state <= w_pre_zero ? DONE : RUN;
    else if (w_expire) r_state <= w_exp_state;
  // done pulses in the cycle the count first reads zero (or is reloaded)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_done <= 1'b0;
    else r_done <= !load && ((start && w_pre_zero) || w_expire);
  assign cout = {4'd0, tens} * 8'd10 + {4'd0, ones};
  assign zero = (tens == 4'd0) && (ones == 4'd0);
  assign busy = (r_state == RUN);
  assign done = r_done;
  logic w_unused;
  assign w_unused = w_borrow_t;
endmodule
